// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: scans four seven-segment digits onto a shared cathode bus.
// Each slot opens with an all-dark blanking interval to suppress ghosting.
module ssd_scan_mux #(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int CNT_W        = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_0,
   input  logic [6:0] seg_1,
   input  logic [6:0] seg_2,
   input  logic [6:0] seg_3,
   input  logic [3:0] en_mask,
   output logic [6:0] cathode,
   output logic [3:0] anode,
   output logic [1:0] digit_idx,
   output logic       scan_tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] pat_q, pat_d, seg_n, cathode_q, cathode_d;
   logic [3:0] anode_q, anode_d;
   logic tick_q, tick_d, wrap, lit;
   // Outputs are computed from next-state values so they align with cnt/idx.
   always_comb begin
      wrap      = cnt_q == CNT_W'(SCAN_DIV - 1);
      cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d     = idx_q + {1'b0, wrap};
      seg_n     = idx_d == 2'd0 ? seg_0 : idx_d == 2'd1 ? seg_1 : idx_d == 2'd2 ? seg_2 : seg_3;
      pat_d     = wrap ? seg_n : pat_q;
      lit       = en_mask[idx_d] && !(int'(cnt_d) < BLANK_CYCLES);
      anode_d   = lit ? ~(4'b0001 << idx_d) : 4'hF;
      cathode_d = lit ? pat_d : 7'h7F;
      tick_d    = wrap && idx_q == 2'd3;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         pat_q     <= 7'h7F;
         anode_q   <= 4'hF;
         cathode_q <= 7'h7F;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pat_q     <= pat_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
         tick_q    <= tick_d;
      end
   end
   assign cathode   = cathode_q;
   assign anode     = anode_q;
   assign digit_idx = idx_q;
   assign scan_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux: directed bench for the scan mux with an 8-cycle slot and 2-cycle blank.
module tb_ssd_scan_mux;
   localparam int SD = 8, BC = 2;
   logic clk = 1'b0, rst = 1'b0;
   logic [6:0] seg_0, seg_1, seg_2, seg_3, cathode, lat;
   logic [3:0] en_mask, anode;
   logic [1:0] digit_idx;
   logic scan_tick;
   int checks = 0, errors = 0, n = 0, ticks = 0, last_tick = -1;

   ssd_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .seg_0(seg_0), .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3),
      .en_mask(en_mask), .cathode(cathode), .anode(anode), .digit_idx(digit_idx), .scan_tick(scan_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int s);
      return s == 0 ? seg_0 : s == 1 ? seg_1 : s == 2 ? seg_2 : seg_3;
   endfunction

   // n counts edges since reset release: cnt = n%8, slot = (n/8)%4.
   task automatic check_state();
      int c, s;
      logic on;
      logic [3:0] ea;
      c = n % SD;
      s = (n / SD) % 4;
      if (c == 0 && n > 0) lat = seg_of(s);
      on = c >= BC && en_mask[s];
      ea = on ? ~(4'b0001 << s) : 4'hF;
      chk("anode", anode, ea);
      chk("cathode", cathode, on ? lat : 7'h7F);
      chk("digit_idx", digit_idx, s);
      chk("scan_tick", scan_tick, n > 0 && n % (4 * SD) == 0);
      chk("one_hot_anode", $countones(~anode) <= 1, 1);
      if (scan_tick) begin
         ticks++;
         if (last_tick >= 0) chk("tick_gap", n - last_tick, 4 * SD);
         last_tick = n;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
      check_state();
   endtask

   initial begin
      seg_0 = 7'h40; seg_1 = 7'h79; seg_2 = 7'h24; seg_3 = 7'h30; en_mask = 4'hF;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("rst_anode", anode, 4'hF);
         chk("rst_cathode", cathode, 7'h7F);
         chk("rst_idx", digit_idx, 0);
         chk("rst_tick", scan_tick, 0);
      end
      rst = 1'b1;
      n = 0;
      lat = 7'h7F;
      check_state();
      repeat (84) step();
      seg_2 = 7'h12;
      repeat (44) step();
      en_mask = 4'b1010;
      repeat (44) step();
      chk("mask_lit_d1", anode, 4'b1101);
      en_mask = 4'b0000;
      step();
      chk("mask_clear_dark", anode, 4'hF);
      en_mask = 4'hF;
      ticks = 0;
      repeat (320) step();
      chk("tick_count", ticks, 10);
      while (n % (4 * SD) != 21) step();
      chk("pre_rst_anode", anode, 4'b1011);
      #2;
      rst = 1'b0;
      #1;
      chk("async_anode", anode, 4'hF);
      chk("async_cathode", cathode, 7'h7F);
      chk("async_idx", digit_idx, 0);
      chk("async_tick", scan_tick, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      n = 0;
      lat = 7'h7F;
      last_tick = -1;
      check_state();
      repeat (40) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Time-multiplexes four per-digit seven-segment patterns onto the board's shared cathode bus and four anode enables.
- Sits directly downstream of the four per-digit ssd decoders in the stopwatch top level.
- Produces the top-level cathode and anode outputs.
- Each digit is lit in turn for a fixed slot. A blanking interval at the start of every slot suppresses ghosting.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot. Must be >= 2. At 100 MHz this gives a 250 Hz frame.
- BLANK_CYCLES, 1000: cycles at the start of each slot during which all anodes are off. Must be < SCAN_DIV. 0 disables blanking.
- CNT_W, 17: width of the slot counter. Must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  master clock (100 MHz board clock)
- rst  input  1  asynchronous reset, active-low (0 = reset)
- seg_0  input  7  cathode pattern for digit 0 (rightmost), active-low, bit0 = segment a … bit6 = segment g
- seg_1  input  7  cathode pattern for digit 1
- seg_2  input  7  cathode pattern for digit 2
- seg_3  input  7  cathode pattern for digit 3 (leftmost)
- en_mask  input  4  per-digit enable; en_mask[i]=0 keeps digit i dark during its slot
- cathode  output  7  shared cathode bus, active-low
- anode  output  4  digit enables, active-low; anode[i] drives digit i
- digit_idx  output  2  index of the digit owning the current slot
- scan_tick  output  1  one-cycle pulse when a full 4-digit frame completes

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, idx=0, latched pattern=7'h7F, anode=4'b1111, cathode=7'h7F, digit_idx=0, scan_tick=0. Reset takes effect immediately, mid-slot or otherwise.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1.
  - On the edge where cnt==SCAN_DIV-1: cnt returns to 0 and idx advances by 1 mod 4 (3 wraps to 0).
- Pattern latch:
  - On every slot-boundary edge, seg_{next idx} is captured into the latched pattern.
  - seg_* changes within a slot never affect the digit currently lit.
  - The first slot after reset (idx=0) shows the reset pattern 7'h7F, i.e. dark, by design.
- Output generation:
  - anode, cathode and digit_idx are registers loaded on the same edge as cnt/idx, from their next values. No extra latency relative to the internal state.
  - Blank region (next cnt < BLANK_CYCLES): anode=4'b1111, cathode=7'h7F.
  - Active region, en_mask[idx]=1: anode = all ones except bit idx = 0; cathode = latched pattern.
  - Active region, en_mask[idx]=0: anode=4'b1111, cathode=7'h7F. The slot still elapses, so scan timing is unchanged.
  - At most one anode bit is ever 0.
- en_mask is sampled every cycle. Clearing it mid-slot darkens the digit on the next edge.
- scan_tick is 1 for exactly the cycle following the edge where idx wraps 3->0. Period = 4*SCAN_DIV cycles.
- Boundaries:
  - BLANK_CYCLES=0: the digit is lit from cnt=0.
  - SCAN_DIV=2, BLANK_CYCLES=1: each digit is lit for 1 cycle per slot.
  - Synchronous reset release: the counter starts at cnt=0, idx=0 on the first edge after rst returns to 1.

Test Plan:
- Reset: SCAN_DIV=8, BLANK_CYCLES=2, hold rst=0 for 5 cycles -> anode=1111, cathode=7F, digit_idx=0, scan_tick=0 throughout.
- Scan order: seg_0..3 = 7'h40, 7'h79, 7'h24, 7'h30; en_mask=1111; run 64 cycles. Per slot: 2 cycles of anode=1111, then 6 cycles of the digit's anode low.
  - Slot 0 of frame 1 is dark.
  - Frame 2 shows anode 1110/7'h40, 1101/7'h79, 1011/7'h24, 0111/7'h30.
  - digit_idx follows 0,1,2,3.
- Tear-free latch: change seg_2 from 7'h24 to 7'h12 at cnt=4 of slot 2 -> cathode stays 7'h24 for the rest of that slot; 7'h12 first appears in slot 2 of the next frame.
- Mask: en_mask=1010 -> anode never 1110 or 1011; cathode=7F during slots 0 and 2; slot length unchanged.
- Frame tick: count scan_tick pulses over 320 cycles -> exactly 10, spaced 32 cycles apart, each one cycle wide.
- Async reset mid-slot: assert rst=0 between clock edges at cnt=5, idx=2 -> anode=1111 and cathode=7F immediately, without waiting for an edge. After release, scanning restarts from idx=0 with a dark first slot.
